// File: rtl/program_counter_unit.sv
// -----------------------------------------------------------------------------
// program_counter_unit
//   Fetch-stage program counter for a MIPS-32 style pipeline. It holds the PC,
//   steps it sequentially, loads aligned branch/jump targets, and keeps a small
//   circular return-address stack (RAS) for call/return. Overflow and underflow
//   of the RAS are recorded in sticky flags that stay set until err_clr.
//
//   Update priority on each rising clk edge: stall > ret > PCSrc > sequential.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   stall         in   hold PC and RAS this cycle (err_clr still acts)
//   PCSrc         in   load setAddress (aligned to INC) into the PC
//   call          in   with PCSrc: push current_pc+INC onto the RAS
//   ret           in   pop RAS top into the PC
//   setAddress    in   branch/jump target
//   err_clr       in   clear sticky fault flags
//   current_pc    out  registered PC
//   pc_plus_inc   out  current_pc + INC, modulo 2^WIDTH (combinational)
//   ras_count     out  number of valid RAS entries
//   ras_empty     out  ras_count == 0
//   ras_full      out  ras_count == RAS_DEPTH
//   ras_overflow  out  sticky: push while full
//   ras_underflow out  sticky: ret while empty
// -----------------------------------------------------------------------------
module program_counter_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         PCSrc,
  input  logic                         call,
  input  logic                         ret,
  input  logic [WIDTH-1:0]             setAddress,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             current_pc,
  output logic [WIDTH-1:0]             pc_plus_inc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  // INC is a power of two, so clearing the bits below it aligns the target.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(INC_W - WIDTH'(1));
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(RAS_DEPTH);

  // Circular stack: sp is the next slot to write, sp-1 is the top. When the
  // stack is full the slot at sp holds the oldest entry, so a push naturally
  // overwrites it.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] top_idx;

  logic [WIDTH-1:0] pc_next;
  logic [PTR_W-1:0] sp_next;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             ovf_set;
  logic             unf_set;

  assign pc_plus_inc = current_pc + INC_W;
  assign top_idx     = sp - PTR_W'(1);
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == DEPTH_C);

  // Next-state selection.
  // NOTE: every signal gets a default before the branches; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    pc_next    = current_pc;
    sp_next    = sp;
    count_next = ras_count;
    push       = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    if (!stall) begin
      if (ret) begin
        if (!ras_empty) begin
          pc_next    = ras_mem[top_idx];
          sp_next    = top_idx;
          count_next = ras_count - CNT_W'(1);
        end else begin
          pc_next = pc_plus_inc;
          unf_set = 1'b1;
        end
      end else if (PCSrc) begin
        pc_next = setAddress & ALIGN_MASK;
        if (call) begin
          push    = 1'b1;
          sp_next = sp + PTR_W'(1);
          if (ras_full) begin
            ovf_set = 1'b1;
          end else begin
            count_next = ras_count + CNT_W'(1);
          end
        end
      end else begin
        pc_next = pc_plus_inc;
      end
    end
  end

  // Control state.
  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_pc    <= RESET_VECTOR;
      sp            <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      current_pc    <= pc_next;
      sp            <= sp_next;
      ras_count     <= count_next;
      // A new fault wins over a clear arriving in the same cycle.
      ras_overflow  <= ovf_set | (ras_overflow  & ~err_clr);
      ras_underflow <= unf_set | (ras_underflow & ~err_clr);
    end
  end

  // Stack storage.
  // NOTE: the storage array has no reset; ras_count/sp say which entries are
  // valid, so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ras_mem[sp] <= pc_plus_inc;
    end
  end

endmodule
